// File: rtl/fsm_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fsm_if : serial bit in / match flag out for the pattern detector |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fsm_if;
  logic in;
  logic out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface
`default_nettype wire

// File: rtl/fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fsm : Moore serial pattern detector, KMP fallback table derived  |
// |       from PATTERN at elaboration time.      Rev 1.0             |
// +------------------------------------------------------------------+
module fsm #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  fsm_if.slave  bus
);

  localparam int SW = $clog2(WIDTH + 1);

  typedef logic [SW-1:0] state_t;

  localparam state_t S_IDLE  = '0;
  localparam state_t S_MATCH = state_t'(WIDTH);

  // Longest proper border of PATTERN (prefix that is also a suffix).
  function automatic int border();
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j < WIDTH; j++) begin
      ok = 1'b1;
      for (int m = 0; m < j; m++)
        if (PATTERN[WIDTH-1-m] != PATTERN[j-1-m]) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

  // Longest prefix of PATTERN that ends the string (first k pattern bits, then b).
  function automatic int step(input int k, input bit b);
    int best;
    int idx;
    bit ok;
    bit sb;
    best = 0;
    for (int j = 1; j <= k + 1; j++) begin
      ok = 1'b1;
      for (int m = 0; m < j; m++) begin
        idx = k + 1 - j + m;
        sb  = (idx == k) ? b : PATTERN[WIDTH-1-idx];
        if (sb != PATTERN[WIDTH-1-m]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  localparam int FAIL_K = OVERLAP ? border() : 0;

  state_t nxt0 [WIDTH+1];
  state_t nxt1 [WIDTH+1];

  for (genvar k = 0; k <= WIDTH; k++) begin : g_state
    localparam int KE = (k == WIDTH) ? FAIL_K : k;
    localparam int N0 = step(KE, 1'b0);
    localparam int N1 = step(KE, 1'b1);
    assign nxt0[k] = state_t'(N0);
    assign nxt1[k] = state_t'(N1);
  end

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Codes above S_MATCH are unreachable; they fall back to idle.
  always_comb begin
    state_nxt = S_IDLE;
    if (state <= S_MATCH)
      state_nxt = bus.in ? nxt1[state] : nxt0[state];
  end

  assign bus.out = (state == S_MATCH);

endmodule
`default_nettype wire

// File: tb/tb_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fsm : directed table plus random stream against a history     |
// |          based reference model.                 Rev 1.0          |
// +------------------------------------------------------------------+
module tb_fsm;

  logic clk;
  logic rst;
  logic din;

  fsm_if bus_a ();
  fsm_if bus_b ();
  fsm_if bus_c ();

  assign bus_a.in = din;
  assign bus_b.in = din;
  assign bus_c.in = din;

  fsm #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  fsm #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  fsm #(.WIDTH(3), .PATTERN(3'b111),  .OVERLAP(1'b1)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          n;
    logic [15:0] bits;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl [5];

  bit ha[$];
  bit hb[$];
  bit hc[$];
  bit ea_m, eb_m, ec_m;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ends_with(input bit h[$], input logic [15:0] p, input int w);
    if (h.size() < w) return 1'b0;
    for (int i = 0; i < w; i++)
      if (h[h.size()-w+i] != p[w-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    ha.delete(); hb.delete(); hc.delete();
    ea_m = 1'b0; eb_m = 1'b0; ec_m = 1'b0;
  endtask

  // Match when the last WIDTH bits seen equal the pattern; non-overlap forgets history on a match.
  task automatic model_push(input bit b);
    ha.push_back(b); if (ha.size() > 4) void'(ha.pop_front());
    hb.push_back(b); if (hb.size() > 4) void'(hb.pop_front());
    hc.push_back(b); if (hc.size() > 3) void'(hc.pop_front());
    ea_m = ends_with(ha, 16'b1011, 4);
    eb_m = ends_with(hb, 16'b1011, 4);
    ec_m = ends_with(hc, 16'b111, 3);
    if (eb_m) hb.delete();
  endtask

  task automatic apply(input bit b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    model_push(b);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_reset(input string name);
    #1 rst = 1'b0;
    model_clear();
    #1;
    chk({name, "_rst_a"}, bus_a.out, 1'b0);
    chk({name, "_rst_b"}, bus_b.out, 1'b0);
    chk({name, "_rst_c"}, bus_c.out, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{"basic",   12, 16'b101111100111, 16'b000100000000, 16'b000100000000, 16'b000011100001};
    tbl[1] = '{"overlap",  7, 16'b1011011,      16'b0001001,      16'b0001000,      16'b0000000};
    tbl[2] = '{"near_s3",  6, 16'b101011,       16'b000001,       16'b000001,       16'b000000};
    tbl[3] = '{"near_s2",  7, 16'b1001011,      16'b0000001,      16'b0000001,      16'b0000000};
    tbl[4] = '{"ones",     5, 16'b11111,        16'b00000,        16'b00000,        16'b00111};

    rst = 1'b0;
    din = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_a", bus_a.out, 1'b0);
    chk("init_b", bus_b.out, 1'b0);
    chk("init_c", bus_c.out, 1'b0);
    rst = 1'b1;

    foreach (tbl[v]) begin
      do_reset(tbl[v].name);
      for (int i = 0; i < tbl[v].n; i++) begin
        apply(tbl[v].bits[tbl[v].n-1-i]);
        chk($sformatf("%s_a[%0d]", tbl[v].name, i), bus_a.out, tbl[v].ea[tbl[v].n-1-i]);
        chk($sformatf("%s_b[%0d]", tbl[v].name, i), bus_b.out, tbl[v].eb[tbl[v].n-1-i]);
        chk($sformatf("%s_c[%0d]", tbl[v].name, i), bus_c.out, tbl[v].ec[tbl[v].n-1-i]);
      end
    end

    // Reset while sitting in S3: a stale S3 would match on the very next 1.
    do_reset("pre_s3");
    apply(1'b1); apply(1'b0); apply(1'b1);
    do_reset("mid_s3");
    apply(1'b1); chk("after_rst_b1", bus_a.out, 1'b0);
    apply(1'b0); chk("after_rst_b2", bus_a.out, 1'b0);
    apply(1'b1); chk("after_rst_b3", bus_a.out, 1'b0);
    apply(1'b1); chk("after_rst_b4", bus_a.out, 1'b1);
    // Reset asserted between edges while out is high must clear it at once.
    do_reset("async_hi");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand");
      end else begin
        apply(1'($urandom_range(0, 1)));
        chk($sformatf("rand_a[%0d]", i), bus_a.out, ea_m);
        chk($sformatf("rand_b[%0d]", i), bus_b.out, eb_m);
        chk($sformatf("rand_c[%0d]", i), bus_c.out, ec_m);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
